// File: rtl/writeback_regfile.sv
// writeback_regfile: write-back stage of the 20-bit pipeline (MEM/WB consumer).
// Decodes the retiring instruction and selects the ALU result or the load data.
// Commits the selected value to a 16-entry register file. r0 is hardwired to 0.
// The file has two combinational read ports for decode.
// It also keeps a registered record of the last commit and a retired-instruction counter.
// Optional build macro: WB_BYPASS_EN. When defined, the read ports are
// write-first and forward the value being committed in the same cycle.
// When undefined, the read ports are read-before-write.
module writeback_regfile #(
  parameter int DATA_W = 20,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [19:0]       instruction,
  input  logic [DATA_W-1:0] aluRESULT,
  input  logic [DATA_W-1:0] memory_read_data,
  input  logic [REG_AW-1:0] rs_addr_a,
  input  logic [REG_AW-1:0] rs_addr_b,
  output logic [DATA_W-1:0] rs_data_a,
  output logic [DATA_W-1:0] rs_data_b,
  output logic              last_we,
  output logic [REG_AW-1:0] last_addr,
  output logic [DATA_W-1:0] last_data,
  output logic [CNT_W-1:0]  retired_count
);

  localparam int NREGS = 2 ** REG_AW;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LOAD = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_LI   = 4'b1001;

  logic [DATA_W-1:0] regs [NREGS];
  logic [3:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic              writes_reg;
  logic              sel_mem;
  logic              we;
  logic [DATA_W-1:0] wr_data;
  logic              unused_instr_bits;

  assign opcode            = instruction[19:16];
  assign rd                = REG_AW'(instruction[15:12]);
  assign unused_instr_bits = ^instruction[11:0];

  // Opcode decode: which instructions write a register and from which source.
  // Non-writing and reserved opcodes fall through to the defaults.
  always_comb begin
    writes_reg = 1'b0;
    sel_mem    = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_LI: writes_reg = 1'b1;
      OP_LOAD: begin
        writes_reg = 1'b1;
        sel_mem    = 1'b1;
      end
      default: ;
    endcase
  end

  // A write to r0 is dropped here, so r0 can never hold anything but 0.
  assign we      = wb_valid && writes_reg && (rd != '0);
  assign wr_data = sel_mem ? memory_read_data : aluRESULT;

  // Register file storage. Reset clears every entry and wins over a pending commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[rd] <= wr_data;
    end
  end

  // Read ports. r0 is forced to 0, and the optional write-first forwarding applies.
  always_comb begin
    rs_data_a = (rs_addr_a == '0) ? '0 : regs[rs_addr_a];
    rs_data_b = (rs_addr_b == '0) ? '0 : regs[rs_addr_b];
`ifdef WB_BYPASS_EN
    if (we && (rs_addr_a == rd)) rs_data_a = wr_data;
    if (we && (rs_addr_b == rd)) rs_data_b = wr_data;
`endif
  end

  // Last-commit record. The address and data read as zero whenever no write happened.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_we   <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      last_we   <= we;
      last_addr <= we ? rd : '0;
      last_data <= we ? wr_data : '0;
    end
  end

  // Retired-instruction counter. It counts every valid slot whatever the opcode.
  // It wraps freely.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_count <= '0;
    end else if (wb_valid) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: table-driven bench for writeback_regfile with a
// scoreboard queue for the last-commit record and a small register model.
module tb_writeback_regfile;

  logic        clock;
  logic        reset;
  logic        wb_valid;
  logic [19:0] instruction;
  logic [19:0] aluRESULT;
  logic [19:0] memory_read_data;
  logic [3:0]  rs_addr_a;
  logic [3:0]  rs_addr_b;
  logic [19:0] rs_data_a;
  logic [19:0] rs_data_b;
  logic        last_we;
  logic [3:0]  last_addr;
  logic [19:0] last_data;
  logic [15:0] retired_count;

  writeback_regfile #(.DATA_W(20), .REG_AW(4), .CNT_W(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .wb_valid         (wb_valid),
    .instruction      (instruction),
    .aluRESULT        (aluRESULT),
    .memory_read_data (memory_read_data),
    .rs_addr_a        (rs_addr_a),
    .rs_addr_b        (rs_addr_b),
    .rs_data_a        (rs_data_a),
    .rs_data_b        (rs_data_b),
    .last_we          (last_we),
    .last_addr        (last_addr),
    .last_data        (last_data),
    .retired_count    (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        valid;
    logic [19:0] instr;
    logic [19:0] alu;
    logic [19:0] mem;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [19:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [19:0] data;
  } exp_t;

  localparam int NVEC = 17;

  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  logic [19:0] model_regs [16];
  logic [15:0] model_count;
  int          tests_run;
  int          tests_failed;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [19:0] instr,
                               input logic [19:0] alu, input logic [19:0] mem);
    wb_valid         = valid;
    instruction      = instr;
    aluRESULT        = alu;
    memory_read_data = mem;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkRecord(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({tag, " last_we"}, 32'(last_we), 32'(e.we));
      checkOutput({tag, " last_addr"}, 32'(last_addr), 32'(e.addr));
      checkOutput({tag, " last_data"}, 32'(last_data), 32'(e.data));
    end
  endtask

  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rs_addr_a = 4'(i);
      rs_addr_b = 4'(15 - i);
      #1;
      checkOutput($sformatf("%s rs_a[%0d]", tag, i), 32'(rs_data_a), 32'(model_regs[i]));
      checkOutput($sformatf("%s rs_b[%0d]", tag, 15 - i), 32'(rs_data_b), 32'(model_regs[15 - i]));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_count  = 16'd0;
    for (int i = 0; i < 16; i++) model_regs[i] = 20'd0;

    //           valid  instr        alu          mem          we    addr   data
    vecs[0]  = '{1'b1, 20'h13000, 20'h0ABCD, 20'h00000, 1'b1, 4'h3, 20'h0ABCD};
    vecs[1]  = '{1'b1, 20'h25000, 20'h00010, 20'hFFFFF, 1'b1, 4'h5, 20'hFFFFF};
    vecs[2]  = '{1'b1, 20'h34000, 20'h11111, 20'h22222, 1'b0, 4'h0, 20'h00000};
    vecs[3]  = '{1'b1, 20'h10000, 20'h12345, 20'h00000, 1'b0, 4'h0, 20'h00000};
    vecs[4]  = '{1'b0, 20'h16000, 20'h0AAAA, 20'h00000, 1'b0, 4'h0, 20'h00000};
    vecs[5]  = '{1'b1, 20'h51000, 20'h00001, 20'h0BBBB, 1'b1, 4'h1, 20'h00001};
    vecs[6]  = '{1'b1, 20'h68000, 20'h0F0F0, 20'h00000, 1'b1, 4'h8, 20'h0F0F0};
    vecs[7]  = '{1'b1, 20'h79000, 20'h0FF00, 20'h00000, 1'b1, 4'h9, 20'h0FF00};
    vecs[8]  = '{1'b1, 20'h8A000, 20'h00001, 20'h00000, 1'b1, 4'hA, 20'h00001};
    vecs[9]  = '{1'b1, 20'h9F000, 20'h76543, 20'h00000, 1'b1, 4'hF, 20'h76543};
    vecs[10] = '{1'b1, 20'h4B000, 20'h0DEAD, 20'h00000, 1'b0, 4'h0, 20'h00000};
    vecs[11] = '{1'b1, 20'hAC000, 20'h0BEEF, 20'h00000, 1'b0, 4'h0, 20'h00000};
    vecs[12] = '{1'b1, 20'hBD000, 20'h11111, 20'h00000, 1'b0, 4'h0, 20'h00000};
    vecs[13] = '{1'b1, 20'hFE000, 20'h22222, 20'h00000, 1'b0, 4'h0, 20'h00000};
    vecs[14] = '{1'b1, 20'h02000, 20'h33333, 20'h00000, 1'b0, 4'h0, 20'h00000};
    vecs[15] = '{1'b1, 20'h2E000, 20'h0CAFE, 20'h04242, 1'b1, 4'hE, 20'h04242};
    vecs[16] = '{1'b0, 20'h23000, 20'h00000, 20'h01234, 1'b0, 4'h0, 20'h00000};

    // Reset state
    reset     = 1'b1;
    rs_addr_a = 4'd0;
    rs_addr_b = 4'd0;
    applyStimulus(1'b0, 20'h00000, 20'h00000, 20'h00000);
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset last_we", 32'(last_we), 32'd0);
    checkOutput("reset retired_count", 32'(retired_count), 32'd0);
    checkAllRegs("reset");

    // Table-driven vectors
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].valid, vecs[v].instr, vecs[v].alu, vecs[v].mem);
      sb_q.push_back('{vecs[v].exp_we, vecs[v].exp_addr, vecs[v].exp_data});
      if (vecs[v].exp_we) model_regs[vecs[v].exp_addr] = vecs[v].exp_data;
      if (vecs[v].valid) model_count = model_count + 16'd1;
      tick();
      checkRecord($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d retired_count", v), 32'(retired_count), 32'(model_count));
    end
    applyStimulus(1'b0, 20'h00000, 20'h00000, 20'h00000);
    checkAllRegs("table");

    // An X instruction in a bubble must neither write nor count
    applyStimulus(1'b0, 20'hxxxxx, 20'h12345, 20'h54321);
    sb_q.push_back('{1'b0, 4'h0, 20'h00000});
    tick();
    checkRecord("x-bubble");
    checkOutput("x-bubble retired_count", 32'(retired_count), 32'(model_count));

    // Same-cycle write/read hazard on r7
    applyStimulus(1'b1, 20'h17000, 20'h55555, 20'h00000);
    rs_addr_a = 4'd7;
    rs_addr_b = 4'd7;
    sb_q.push_back('{1'b1, 4'h7, 20'h55555});
    #1;
`ifdef WB_BYPASS_EN
    checkOutput("hazard same-cycle rs_a", 32'(rs_data_a), 32'h55555);
    checkOutput("hazard same-cycle rs_b", 32'(rs_data_b), 32'h55555);
`else
    checkOutput("hazard same-cycle rs_a", 32'(rs_data_a), 32'h00000);
    checkOutput("hazard same-cycle rs_b", 32'(rs_data_b), 32'h00000);
`endif
    model_regs[7] = 20'h55555;
    model_count   = model_count + 16'd1;
    tick();
    applyStimulus(1'b0, 20'h00000, 20'h00000, 20'h00000);
    #1;
    checkRecord("hazard");
    checkOutput("hazard next-cycle rs_a", 32'(rs_data_a), 32'h55555);
    checkOutput("hazard next-cycle rs_b", 32'(rs_data_b), 32'h55555);

    // Counter wrap: run valid NOPs up to 0xFFFF, then one more
    applyStimulus(1'b1, 20'h00000, 20'h00000, 20'h00000);
    while (model_count != 16'hFFFF) begin
      @(posedge clock);
      model_count = model_count + 16'd1;
    end
    #1;
    checkOutput("count at max", 32'(retired_count), 32'h0000FFFF);
    tick();
    checkOutput("count wrap", 32'(retired_count), 32'h00000000);
    model_count = 16'd0;

    // Reset wins over a simultaneous write and count
    applyStimulus(1'b1, 20'h12000, 20'h22222, 20'h00000);
    tick();
    rs_addr_a = 4'd2;
    #1;
    checkOutput("r2 before reset", 32'(rs_data_a), 32'h22222);
    reset = 1'b1;
    applyStimulus(1'b1, 20'h12000, 20'h33333, 20'h00000);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 20'h00000, 20'h00000, 20'h00000);
    for (int i = 0; i < 16; i++) model_regs[i] = 20'd0;
    #1;
    checkOutput("reset-write r2", 32'(rs_data_a), 32'h00000);
    checkOutput("reset-write count", 32'(retired_count), 32'h00000);
    checkOutput("reset-write last_we", 32'(last_we), 32'd0);
    checkAllRegs("post-reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back stage of the 20-bit pipeline: the consumer end of the MEM/WB interface.
- Takes the MEM/WB outputs (instruction, ALU result, memory read data), decodes the opcode, selects the write-back source and commits it to a 16-entry register file.
- Provides two asynchronous read ports to the decode stage, a registered record of the last commit, and a retired-instruction counter.

Parameters:
- DATA_W, 20, datapath and register width
- REG_AW, 4, register address width (2**REG_AW registers)
- CNT_W, 16, retired-instruction counter width

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wb_valid  input  1  MEM/WB slot holds a real instruction (0 = bubble)
- instruction  input  20  instruction from MEM/WB; opcode [19:16], rd [15:12]
- aluRESULT  input  DATA_W  ALU result from MEM/WB
- memory_read_data  input  DATA_W  load data from MEM/WB
- rs_addr_a  input  REG_AW  read port A address
- rs_addr_b  input  REG_AW  read port B address
- rs_data_a  output  DATA_W  read port A data (combinational)
- rs_data_b  output  DATA_W  read port B data (combinational)
- last_we  output  1  registered: a register write committed last cycle
- last_addr  output  REG_AW  registered: destination of that write
- last_data  output  DATA_W  registered: value written
- retired_count  output  CNT_W  number of valid instructions retired

Behaviour:
- Opcode decode (instruction[19:16]):
  - Writes ALU result: 0001 ADD, 0101 SUB, 0110 AND, 0111 OR, 1000 SLT, 1001 LI.
  - Writes memory_read_data: 0010 LOAD.
  - No register write: 0000 NOP, 0011 STORE, 0100 BEQ, 1010 JMP, 1011-1111 reserved.
- Write enable: we = wb_valid AND opcode is a writing opcode AND rd != 0.
- Register r0 always reads 0 and is never written. A write to rd=0 is dropped: last_we=0, but the instruction still retires.
- Commit: when we=1, at the rising edge regs[rd] <= selected value. One write per cycle; latency 1 clock from MEM/WB inputs to register-file update.
- last_we, last_addr, last_data update every clock:
  - last_we <= we
  - when we=0: last_addr <= 0, last_data <= 0
- retired_count increments by 1 each clock with wb_valid=1, regardless of opcode. It wraps from 2**CNT_W-1 to 0 with no saturation or flag.
- Read ports are purely combinational on rs_addr and register contents. Same-cycle write/read to the same address is governed by the Optional Feature.
- Reset (synchronous, active-high; clock drives all state):
  - All registers, last_we, last_addr, last_data and retired_count go to 0 on the first rising edge with reset=1.
  - Reset overrides any simultaneous write: no commit occurs and the counter does not increment in that cycle.
- Reset mid-stream: the instruction present at that edge is discarded. The pipeline must re-present it if it is still wanted.
- Inputs are sampled only at the clock edge. X on instruction while wb_valid=0 must not cause a write or a count.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: write-first register file. If we=1 and rs_addr_x == rd (rd != 0), rs_data_x returns the value being written this cycle. This covers the WB→ID hazard without a pipeline stall.
- Undefined: read-before-write. rs_data_x returns the stored value, and the value being written appears the cycle after. Decode must stall one extra cycle for that hazard.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then read all 16 addresses on both ports -> every read 0, last_we=0, retired_count=0.
- wb_valid=1, instruction=0x1_3_000 (ADD, rd=3), aluRESULT=0x0ABCD -> next cycle regs[3]=0x0ABCD, last_we=1, last_addr=3, last_data=0x0ABCD, retired_count=1.
- wb_valid=1, opcode 0010 (LOAD), rd=5, aluRESULT=0x00010, memory_read_data=0xFFFFF -> regs[5]=0xFFFFF; the ALU value is not written.
- Three cycles: STORE rd=4, ADD rd=0 with aluRESULT=0x12345, then a bubble (wb_valid=0, ADD rd=6) -> regs[4], regs[0], regs[6] unchanged; last_we=0 throughout; retired_count +2.
- ADD rd=7 data 0x55555 with rs_addr_a=7 in the same cycle -> rs_data_a=0x55555 same cycle with WB_BYPASS_EN defined, old value (0) without; both builds read 0x55555 the next cycle.
- Force retired_count to 0xFFFF via 65535 valid cycles, then one more valid cycle -> 0x0000. Assert reset concurrently with a valid ADD rd=2 -> regs[2]=0 and count=0 after that edge.
